// File: rtl/csa_multiword_add_seq_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
package csa_multiword_add_seq_pkg;

  localparam int unsigned WORD_W = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/carry_select_8b_adder.sv
// Combinational 8-bit carry-select adder: ripple low nibble, pre-computed high nibble pair.
module carry_select_8b_adder
  import csa_multiword_add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] s_o,
  output logic              cout_o
);

  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  always_comb begin
    lo  = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0, cin_i};
    hi0 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]};
    hi1 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + 5'd1;
    // Low-nibble carry picks which speculative high half is real
    if (lo[4]) begin
      s_o    = {hi1[3:0], lo[3:0]};
      cout_o = hi1[4];
    end else begin
      s_o    = {hi0[3:0], lo[3:0]};
      cout_o = hi0[4];
    end
  end

endmodule

// File: rtl/csa_multiword_add_seq.sv
// Byte-serial multi-precision add/subtract around one shared 8-bit carry-select adder.
module csa_multiword_add_seq
  import csa_multiword_add_seq_pkg::*;
#(
  parameter int unsigned NWORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [8*NWORDS-1:0]    a_in,
  input  logic [8*NWORDS-1:0]    b_in,
  input  logic                   cin_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NWORDS-1:0]    sum_out,
  output logic                   cout_out,
  output logic                   ovf_out,
  output logic                   busy
);

  localparam int unsigned W    = WORD_W * NWORDS;
  localparam int unsigned CntW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NWORDS - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  int unsigned       byte_idx;
  logic [WORD_W-1:0] add_s;
  logic              add_cout;

  assign byte_idx = 32'(cnt_q) << 3;

  carry_select_8b_adder u_adder (
    .a_i    (a_q[byte_idx +: WORD_W]),
    .b_i    (b_q[byte_idx +: WORD_W]),
    .cin_i  (carry_q),
    .s_o    (add_s),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a_in;
          // Subtraction as a + ~b + ~borrow
          b_d     = op_sub ? ~b_in : b_in;
          carry_d = op_sub ^ cin_in;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[byte_idx +: WORD_W] = add_s;
        carry_d = add_cout;
        if (cnt_q == CntLast) begin
          cout_d  = add_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (add_s[7] != a_q[W-1]);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum_out   = sum_q;
  assign cout_out  = cout_q;
  assign ovf_out   = ovf_q;

endmodule
